// File: rtl/deglitch_sched_pkg.sv
// Shared constants and types for the round-robin input deglitcher.
// One compare unit is time-shared across NUM_CH channels, one channel per slot.
package deglitch_sched_pkg;

   localparam int NUM_CH = 4;
   localparam int SLOT_W = 2;
   localparam int THR_W  = 4;

   localparam logic [THR_W-1:0] DEFAULT_THR = 4'd3;

   typedef logic [SLOT_W-1:0] slot_t;
   typedef logic [THR_W-1:0]  thr_t;
   typedef logic [NUM_CH-1:0] ch_vec_t;

   // A raw threshold of zero behaves exactly like a threshold of one.
   function automatic thr_t eff_thr_of(input thr_t thr);
      return (thr == '0) ? thr_t'(1) : thr;
   endfunction

endpackage

// File: rtl/deglitch_lane.sv
// Combinational single-channel evaluation: compares the synchronized level with
// the current output and produces the next counter, next level and flip flag.
module deglitch_lane
   import deglitch_sched_pkg::*;
(
   input  logic sync_bit,
   input  logic level,
   input  thr_t cnt,
   input  thr_t eff_thr,
   output logic nxt_level,
   output thr_t nxt_cnt,
   output logic flip
);

   logic disagree;
   logic at_limit;

   assign disagree = (sync_bit != level);
   assign at_limit = (cnt == thr_t'(eff_thr - thr_t'(1)));

   always_comb begin
      nxt_level = level;
      nxt_cnt   = '0;
      flip      = 1'b0;
      if (disagree) begin
         if (at_limit) begin
            nxt_level = sync_bit;
            flip      = 1'b1;
         end else begin
            // cnt stays below eff_thr, so the increment cannot wrap
            nxt_cnt = cnt + thr_t'(1);
         end
      end
   end

endmodule

// File: rtl/deglitch_sched.sv
// Four-channel deglitcher: 2-flop synchronizers on every line, then a single
// shared compare lane that visits one channel per clock in round-robin order.
module deglitch_sched
   import deglitch_sched_pkg::*;
#(
   parameter logic [THR_W-1:0] DEFAULT_THR = deglitch_sched_pkg::DEFAULT_THR
)
(
   input  logic             clk_16M,
   input  logic             rst_n,
   input  logic [NUM_CH-1:0] dat_i,
   input  logic             cfg_valid,
   input  logic [THR_W-1:0] cfg_thr,
   output logic             cfg_ready,
   output logic [NUM_CH-1:0] dat_o,
   output logic [NUM_CH-1:0] edge_o,
   output logic [THR_W-1:0] thr_o
);

   ch_vec_t sync_p0;
   ch_vec_t sync_p1;
   slot_t   slot;
   thr_t    thr;
   thr_t    cnt [NUM_CH];

   logic    xfer;
   logic    lane_sync;
   logic    lane_level;
   thr_t    lane_cnt;
   logic    lane_nxt_level;
   thr_t    lane_nxt_cnt;
   logic    lane_flip;
   ch_vec_t dat_nxt;
   ch_vec_t edge_nxt;

   assign cfg_ready = (slot == slot_t'(NUM_CH - 1));
   assign xfer      = cfg_valid && cfg_ready;
   assign thr_o     = thr;

   // Stage p0/p1: metastability synchronizer, runs on every channel every cycle
   always_ff @(posedge clk_16M or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= dat_i;
         sync_p1 <= sync_p0;
      end
   end

   // Evaluation stage: select the slot's channel into the shared lane
   assign lane_sync  = sync_p1[slot];
   assign lane_level = dat_o[slot];
   assign lane_cnt   = cnt[slot];

   deglitch_lane u_lane (
      .sync_bit  (lane_sync),
      .level     (lane_level),
      .cnt       (lane_cnt),
      .eff_thr   (eff_thr_of(thr)),
      .nxt_level (lane_nxt_level),
      .nxt_cnt   (lane_nxt_cnt),
      .flip      (lane_flip)
   );

   always_comb begin
      dat_nxt        = dat_o;
      dat_nxt[slot]  = lane_nxt_level;
      edge_nxt       = '0;
      edge_nxt[slot] = lane_flip;
   end

   always_ff @(posedge clk_16M or negedge rst_n) begin
      if (!rst_n) begin
         slot   <= '0;
         thr    <= DEFAULT_THR;
         dat_o  <= '0;
         edge_o <= '0;
         for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
      end else begin
         slot   <= slot + slot_t'(1);
         dat_o  <= dat_nxt;
         edge_o <= edge_nxt;
         // A config transfer restarts every count, overriding the slot-3 update
         if (xfer) begin
            thr <= cfg_thr;
            for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
         end else begin
            cnt[slot] <= lane_nxt_cnt;
         end
      end
   end

endmodule
